// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - default geometry and pointer width helper for synchronous_fifo
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 8;

    // Pointer carries one extra wrap bit above the storage address.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_W register array, sync write, registered read
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value when no read is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/synchronous_fifo.sv
// rtl/synchronous_fifo.sv - single-clock FIFO; SYNC_FIFO_ERR_EN adds sticky overflow/underflow
module synchronous_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
`ifdef SYNC_FIFO_ERR_EN
    output logic              overflow,
    output logic              underflow,
`endif
    output logic              empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ptr_width(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_d;
    logic             wr_en;
    logic             rd_en;

    // Flags come straight from the pointers; wrap bit distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    // Each strobe is qualified independently against the pre-edge flags.
    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;

    // Next-state pointers; natural roll-over handles wrap.
    always_comb begin
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        if (wr_en) begin
            wr_ptr_d = wr_ptr + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr + PTR_W'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (din),
        .re    (rd_en),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (dout)
    );

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr && full) begin
                overflow_q <= 1'b1;
            end
            if (rd && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_synchronous_fifo.sv
// tb/tb_synchronous_fifo.sv - directed self-checking bench for synchronous_fifo
`timescale 1ns/1ps
module tb_synchronous_fifo;

    logic       clk;
    logic       rst;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
`ifdef SYNC_FIFO_ERR_EN
    logic       overflow;
    logic       underflow;
`endif

    int errors = 0;
    int checks = 0;

    synchronous_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr),
        .rd        (rd),
        .din       (din),
        .dout      (dout),
        .full      (full),
`ifdef SYNC_FIFO_ERR_EN
        .overflow  (overflow),
        .underflow (underflow),
`endif
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply strobes after a rising edge, then sample 1 ns after the next edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        wr  = w;
        rd  = r;
        din = d;
        @(posedge clk);
        #1;
        wr  = 1'b0;
        rd  = 1'b0;
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_d;
    logic [3:0] occ;

    initial begin
        rst = 1'b1;
        wr  = 1'b0;
        rd  = 1'b0;
        din = 8'h00;

        // 1. Reset asserted mid-clock acts immediately.
        #13;
        rst = 1'b0;
        #1;
        check("rst_dout",   dout,        32'd0);
        check("rst_empty",  empty,       32'd1);
        check("rst_full",   full,        32'd0);
        check("rst_wr_ptr", dut.wr_ptr,  32'd0);
        check("rst_rd_ptr", dut.rd_ptr,  32'd0);
`ifdef SYNC_FIFO_ERR_EN
        check("rst_ovf",    overflow,    32'd0);
        check("rst_udf",    underflow,   32'd0);
`endif
        #9;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 2. Fill with 1..8.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 8'(i));
            if (i == 1) check("fill_empty_drop", empty, 32'd0);
            if (i == 7) check("fill_not_full7",  full,  32'd0);
        end
        check("fill_full",   full,       32'd1);
        check("fill_wr_ptr", dut.wr_ptr, 32'd8);
        check("fill_rd_ptr", dut.rd_ptr, 32'd0);

        // 3. Write while full is dropped.
        step(1'b1, 1'b0, 8'd9);
        check("ovf_wr_ptr", dut.wr_ptr, 32'd8);
        check("ovf_full",   full,       32'd1);
`ifdef SYNC_FIFO_ERR_EN
        check("ovf_flag",   overflow,   32'd1);
`endif

        // 4. Drain returns 1..8 in order.
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check($sformatf("drain_%0d", i), dout, 32'(i));
        end
        check("drain_empty",  empty,      32'd1);
        check("drain_full",   full,       32'd0);
        check("drain_rd_ptr", dut.rd_ptr, 32'd8);

        // 5. Read while empty is ignored.
        step(1'b0, 1'b1, 8'h00);
        check("udf_dout",   dout,       32'd8);
        check("udf_rd_ptr", dut.rd_ptr, 32'd8);
`ifdef SYNC_FIFO_ERR_EN
        check("udf_flag",   underflow,  32'd1);
`endif

        // 6. Preload 3 entries, then 20 edges of concurrent rd&wr across the wrap.
        q = {};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'(50 + i));
            q.push_back(8'(50 + i));
        end
        check("pre_wr_ptr", dut.wr_ptr, 32'd11);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1, 8'(100 + k));
            exp_d = q.pop_front();
            q.push_back(8'(100 + k));
            occ = dut.wr_ptr - dut.rd_ptr;
            check($sformatf("wrap_dout_%0d", k), dout, 32'(exp_d));
            check($sformatf("wrap_occ_%0d", k),  occ,  32'd3);
        end
        check("wrap_wr_ptr", dut.wr_ptr, 32'd15);
        check("wrap_rd_ptr", dut.rd_ptr, 32'd12);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check($sformatf("tail_%0d", i), dout, 32'(117 + i));
        end
        check("tail_empty", empty, 32'd1);

        // Mid-operation reset discards data and clears sticky flags.
        step(1'b1, 1'b0, 8'h44);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_empty", empty, 32'd1);
        check("mid_rst_dout",  dout,  32'd0);
`ifdef SYNC_FIFO_ERR_EN
        check("mid_rst_ovf",   overflow,  32'd0);
        check("mid_rst_udf",   underflow, 32'd0);
`endif
        #4;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_empty", empty, 32'd1);

        // Concurrent rd&wr while empty: only the write lands, no fall-through.
        step(1'b1, 1'b1, 8'd77);
        check("ce_dout",   dout,       32'd0);
        check("ce_wr_ptr", dut.wr_ptr, 32'd1);
        check("ce_rd_ptr", dut.rd_ptr, 32'd0);

        // Concurrent rd&wr while full: only the read lands.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, 8'(78 + i));
        end
        check("cf_full_before", full, 32'd1);
        step(1'b1, 1'b1, 8'd99);
        check("cf_dout",   dout,       32'd77);
        check("cf_wr_ptr", dut.wr_ptr, 32'd8);
        check("cf_rd_ptr", dut.rd_ptr, 32'd1);
        check("cf_full",   full,       32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
